// File: rtl/wb_arbiter2_if.sv
// Wishbone bundle for the two-master arbiter: both master ports, the shared
// slave-side port and the grant vector.
interface wb_arbiter2_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_cyc;
    logic          m0_stb;
    logic          m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_o;
    logic [DW-1:0] m0_dat_i;
    logic          m0_ack;
    logic          m0_err;

    logic          m1_cyc;
    logic          m1_stb;
    logic          m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_o;
    logic [DW-1:0] m1_dat_i;
    logic          m1_ack;
    logic          m1_err;

    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack;

    logic [1:0]    gnt;

    // Arbiter view: it is the slave of both masters and drives the shared port.
    modport slave (
        input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
        output m0_dat_i, m0_ack, m0_err,
        input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
        output m1_dat_i, m1_ack, m1_err,
        output s_cyc, s_stb, s_we, s_adr, s_dat_o,
        input  s_dat_i, s_ack,
        output gnt
    );

    // Environment view: the two masters plus the downstream responder.
    modport master (
        output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
        input  m0_dat_i, m0_ack, m0_err,
        output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
        input  m1_dat_i, m1_ack, m1_err,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_o,
        output s_dat_i, s_ack,
        input  gnt
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin on ties, bus lock while cyc is held,
// combinational request/ack paths and a stall watchdog that aborts hung cycles.
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter2_if.slave bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t        state_reg;
    logic          last_reg;
    logic [CW-1:0] cnt_reg;

    logic [1:0]    m_cyc;
    logic [1:0]    m_stb;
    logic [1:0]    m_we;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [1:0]    gnt_vec;
    logic [1:0]    m_ack;
    logic [1:0]    m_err;
    logic          granted;
    logic          sel;
    logic          stalled;
    logic          timeout_hit;

    assign m_cyc    = {bus.m1_cyc, bus.m0_cyc};
    assign m_stb    = {bus.m1_stb, bus.m0_stb};
    assign m_we     = {bus.m1_we,  bus.m0_we};
    assign m_adr[0] = bus.m0_adr;
    assign m_adr[1] = bus.m1_adr;
    assign m_dat[0] = bus.m0_dat_o;
    assign m_dat[1] = bus.m1_dat_o;

    assign gnt_vec = {state_reg == GNT1, state_reg == GNT0};
    assign granted = |gnt_vec;
    assign sel     = gnt_vec[1];
    assign stalled = granted & bus.s_stb & ~bus.s_ack;

    // The error fires on the stall that would bring the count to TIMEOUT, so an
    // ack in that same cycle suppresses it.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign timeout_hit = stalled & (cnt_reg == CW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign bus.s_cyc   = granted & m_cyc[sel];
    assign bus.s_stb   = granted & m_stb[sel];
    assign bus.s_we    = granted & m_we[sel];
    assign bus.s_adr   = m_adr[sel];
    assign bus.s_dat_o = m_dat[sel];
    assign bus.gnt     = gnt_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign m_ack[gi] = gnt_vec[gi] & bus.s_ack;
            assign m_err[gi] = gnt_vec[gi] & timeout_hit;
        end
    endgenerate

    assign bus.m0_ack   = m_ack[0];
    assign bus.m0_err   = m_err[0];
    assign bus.m1_ack   = m_ack[1];
    assign bus.m1_err   = m_err[1];
    assign bus.m0_dat_i = bus.s_dat_i;
    assign bus.m1_dat_i = bus.s_dat_i;

    function automatic state_t grant_of(input logic idx);
        return idx ? GNT1 : GNT0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (m_cyc == 2'b11) begin
                        state_reg <= grant_of(~last_reg);
                        last_reg  <= ~last_reg;
                    end else if (m_cyc[0]) begin
                        state_reg <= GNT0;
                        last_reg  <= 1'b0;
                    end else if (m_cyc[1]) begin
                        state_reg <= GNT1;
                        last_reg  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (timeout_hit) begin
                        state_reg <= ABORT;
                        cnt_reg   <= '0;
                    end else if (!m_cyc[sel]) begin
                        cnt_reg <= '0;
                        // Hand straight over when the other master is waiting.
                        if (m_cyc[~sel]) begin
                            state_reg <= grant_of(~sel);
                            last_reg  <= ~sel;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (stalled && TIMEOUT > 0) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                ABORT: begin
                    cnt_reg <= '0;
                    if (!m_cyc[last_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter AW, default 16, Wishbone address width.
REQ-002 Parameter DW, default 16, Wishbone data width.
REQ-003 Parameter TIMEOUT, default 255, cycles of unacknowledged strobe before abort; 0 disables the watchdog.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 m0_cyc, m0_stb, m0_we  input  1 each  master 0 bus cycle, strobe, write enable.
REQ-007 m0_adr  input  AW; m0_dat_o  input  DW  master 0 address and write data.
REQ-008 m0_dat_i  output  DW; m0_ack, m0_err  output  1 each  master 0 read data, acknowledge, error.
REQ-009 m1_* ports SHALL be identical to m0_* (REQ-006..008) for master 1.
REQ-010 s_cyc, s_stb, s_we  output  1 each; s_adr  output  AW; s_dat_o  output  DW  slave-side request toward interconnect.
REQ-011 s_dat_i  input  DW; s_ack  input  1  slave-side read data and acknowledge.
REQ-012 gnt  output  2  one-hot current grant (bit0 master 0, bit1 master 1), 00 when none.

Function
REQ-013 FSM states SHALL be IDLE, GNT0, GNT1, ABORT; a 1-bit register last holds the most recently granted master.
REQ-014 IDLE: s_cyc=s_stb=0, gnt=00; next state GNT0/GNT1 when the corresponding mX_cyc=1, decided same cycle, effective next edge.
REQ-015 Simultaneous m0_cyc=m1_cyc=1 in IDLE SHALL grant the master not equal to last (round-robin).
REQ-016 GNTx: s_cyc/s_stb/s_we/s_adr/s_dat_o SHALL be combinational copies of master x; gnt one-hot x; last<=x on entry.
REQ-017 Grant SHALL be held while mX_cyc=1 (bus lock across multiple strobes, read-modify-write).
REQ-018 GNTx with mX_cyc=0: if the other master's cyc=1, go directly to GNT(other); else IDLE; no dead cycle required on a direct switch.
REQ-019 mX_ack = s_ack AND (state==GNTx); non-granted master ack=0 and err=0 always.
REQ-020 m0_dat_i and m1_dat_i SHALL both equal s_dat_i (qualified only by ack).
REQ-021 Arbitration latency: mX_cyc rising in IDLE -> s_cyc=1 exactly one cycle later; no added latency on the ack path (combinational).
REQ-022 Watchdog counter (width clog2(TIMEOUT+1)) SHALL clear on state entry, on s_ack, and when s_stb=0; increments each GNTx cycle with s_stb=1 and s_ack=0.
REQ-023 When the counter reaches TIMEOUT in GNTx: mX_err=1 for exactly that cycle, next state ABORT.
REQ-024 ABORT: s_cyc=s_stb=0, gnt=00, no ack/err; stay until the aborted master's cyc=0, then apply REQ-018 selection from IDLE rules (go IDLE, taking other master next cycle if requesting).
REQ-025 s_ack arriving in the same cycle the counter would reach TIMEOUT SHALL win: ack delivered, no err, counter cleared.
REQ-026 s_ack received while state is IDLE or ABORT SHALL be ignored.
REQ-027 TIMEOUT=0: counter held at 0, ABORT unreachable.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, last=1 (master 0 wins first tie), counter=0.
REQ-029 During and immediately after reset: s_cyc=s_stb=s_we=0, gnt=00, m0/m1 ack=err=0; s_adr/s_dat_o value don't-care but driven.
REQ-030 Reset asserted mid-transfer SHALL drop s_cyc in the same cycle; no ack forwarded thereafter.

Verification
REQ-031 Reset release, m0_cyc=m1_cyc=1 same cycle -> gnt=01 next cycle; m0 drops cyc -> gnt=10 next cycle with no IDLE gap.
REQ-032 m1 holds cyc across 3 strobes while m0 requests -> gnt stays 10 until m1_cyc=0; m0_ack=0 throughout.
REQ-033 TIMEOUT=4, m0 strobes, s_ack never -> m0_err=1 on 4th stalled cycle only, s_cyc=0 until m0_cyc=0.
REQ-034 TIMEOUT=4, s_ack on 4th stalled cycle -> m0_ack=1, m0_err=0, grant retained.
REQ-035 Read from m1, s_dat_i=16'hBEEF with s_ack -> m1_dat_i=16'hBEEF, m1_ack=1, m0_ack=0 same cycle.
REQ-036 rst_n low during GNT1 with s_stb=1 -> s_cyc=0 and gnt=00 before next clock edge; after release tie grants master 0.
